// File: rtl/seg_display_decoder_pkg.sv
// Shared constants for the seven-segment readback decoder: segment codes
// for digits 0..7 (order {a,b,c,d,e,f,g}, active high), FSM state encoding
// and display-mode encoding.
package seg_dec_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;

  localparam logic MODE_OCTAL = 1'b0;
  localparam logic MODE_GRAY  = 1'b1;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_DECODE = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/seg_display_decoder_seg7_to_digit.sv
// Combinational seven-segment to digit lookup. known=0 flags any code that
// is not one of the eight digit patterns; digit is then forced to 0.
module seg7_to_digit
  import seg_dec_pkg::*;
(
  input  logic [6:0] seg,
  output logic [2:0] digit,
  output logic       known
);

  // Map each legal segment code to its digit value
  always_comb begin
    digit = 3'd0;
    known = 1'b1;
    case (seg)
      SEG_0:   digit = 3'd0;
      SEG_1:   digit = 3'd1;
      SEG_2:   digit = 3'd2;
      SEG_3:   digit = 3'd3;
      SEG_4:   digit = 3'd4;
      SEG_5:   digit = 3'd5;
      SEG_6:   digit = 3'd6;
      SEG_7:   digit = 3'd7;
      default: known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_display_decoder.sv
// Dual seven-segment readback decoder. Samples the display bus, waits for
// STABLE_CYCLES consecutive matching samples, decodes both digits (octal or
// Gray format) and holds the result on Valid_out until Ack_in.
// Handshake: Valid_out rises when a report is ready and stays high with
// Value_out/Err_out frozen until a cycle with Ack_in=1; Valid_out drops on
// the following edge. Ack_in while Valid_out=0 has no effect.
// Optional feature macro: SEG_DEC_ERRCNT_EN adds Err_cnt_out, a saturating
// count of error reports.
module seg_display_decoder
  import seg_dec_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] Disp_in,
  input  logic        Mode_in,
  input  logic        Ack_in,
  output logic [3:0]  Value_out,
  output logic        Valid_out,
`ifdef SEG_DEC_ERRCNT_EN
  output logic        Err_out,
  output logic [7:0]  Err_cnt_out
`else
  output logic        Err_out
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [13:0]   disp_q;
  logic          mode_q;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [14:0]   last_q, last_d;
  logic          have_last_q, have_last_d;
  logic [3:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic          sample_match;
  logic [2:0]    left_digit, right_digit;
  logic          left_known, right_known;
  logic [3:0]    dec_value;
  logic          dec_err;
  logic [3:0]    gray_g;

  seg7_to_digit u_left (
    .seg   (disp_q[13:7]),
    .digit (left_digit),
    .known (left_known)
  );

  seg7_to_digit u_right (
    .seg   (disp_q[6:0]),
    .digit (right_digit),
    .known (right_known)
  );

  // Stability counter: a fresh sample matching the held one counts up
  always_comb begin
    sample_match = (Disp_in == disp_q) && (Mode_in == mode_q);
    cnt_d        = '0;
    if (sample_match) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Digit pair to ALU value; range violations become error reports
  always_comb begin
    dec_value = 4'd0;
    dec_err   = 1'b1;
    gray_g    = {left_digit[1:0], right_digit[1:0]};
    if (mode_q == MODE_OCTAL) begin
      if (left_known && right_known && (left_digit <= 3'd1)) begin
        dec_value = {left_digit[0], right_digit};
        dec_err   = 1'b0;
      end
    end else begin
      if (left_known && right_known && !left_digit[2] && !right_digit[2]) begin
        dec_value[3] = gray_g[3];
        dec_value[2] = dec_value[3] ^ gray_g[2];
        dec_value[1] = dec_value[2] ^ gray_g[1];
        dec_value[0] = dec_value[1] ^ gray_g[0];
        dec_err      = 1'b0;
      end
    end
  end

  // FSM next state and report registers. The WAIT exit uses the counter's
  // next value so the report lands STABLE_CYCLES+2 edges after the change.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    value_d     = value_q;
    err_d       = err_q;
    valid_d     = valid_q;
    case (state_q)
      ST_WAIT: begin
        if ((cnt_d == CNT_MAX) &&
            (!have_last_q || ({mode_q, disp_q} != last_q))) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        last_d      = {mode_q, disp_q};
        have_last_d = 1'b1;
        value_d     = dec_value;
        err_d       = dec_err;
        valid_d     = 1'b1;
        state_d     = ST_REPORT;
      end
      ST_REPORT: begin
        if (Ack_in) begin
          valid_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_WAIT;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, sampler and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q      <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_WAIT;
      last_q      <= '0;
      have_last_q <= 1'b0;
      value_q     <= 4'd0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      disp_q      <= Disp_in;
      mode_q      <= Mode_in;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      value_q     <= value_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
    end
  end

  assign Value_out = value_q;
  assign Valid_out = valid_q;
  assign Err_out   = err_q;

`ifdef SEG_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count error reports as they enter REPORT, saturating at 255
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == ST_DECODE) && dec_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign Err_cnt_out = err_cnt_q;
`endif

endmodule
